// File: rtl/axi_rb_pkg.sv
// Shared types and AXI constants for the burst-read kernel.
package axi_rb_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_AR   = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam int unsigned SKID_DEPTH    = 2;

endpackage

// File: rtl/axi_rb_skid.sv
// Two-entry FIFO decoupling the AXI R channel from the downstream FIFO.
module axi_rb_skid
  import axi_rb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_c,
  output logic                  o_full_c,
  output logic                  o_empty_c
);

  localparam int unsigned CNT_W = 2;

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full_c  = (r_count == CNT_W'(SKID_DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full_c;
  assign w_pop_ok  = i_pop && !o_empty_c;

  // Entries are cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_rb.sv
// Single AXI4 INCR read burst: length/address from RAM ports, beats streamed to a FIFO.
module axi_rb
  import axi_rb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_WIDTH-1:0]   arg_3_s_axi_araddr,
  output logic [1:0]              arg_3_s_axi_arburst,
  output logic [LEN_WIDTH-1:0]    arg_3_s_axi_arlen,
  output logic [2:0]              arg_3_s_axi_arsize,
  output logic                    arg_3_s_axi_arvalid,
  input  logic                    arg_3_s_axi_arready,
  input  logic [DATA_WIDTH-1:0]   arg_3_s_axi_rdata,
  input  logic                    arg_3_s_axi_rvalid,
  output logic                    arg_3_s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   arg_3_s_axi_awaddr,
  output logic [1:0]              arg_3_s_axi_awburst,
  output logic [LEN_WIDTH-1:0]    arg_3_s_axi_awlen,
  output logic [2:0]              arg_3_s_axi_awsize,
  output logic                    arg_3_s_axi_awvalid,
  input  logic                    arg_3_s_axi_awready,
  output logic [DATA_WIDTH-1:0]   arg_3_s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] arg_3_s_axi_wstrb,
  output logic                    arg_3_s_axi_wvalid,
  input  logic                    arg_3_s_axi_wready,
  input  logic                    arg_3_s_axi_bvalid,
  output logic                    arg_3_s_axi_bready,
  output logic [LEN_WIDTH-1:0]    arg_1_raddr,
  output logic [LEN_WIDTH-1:0]    arg_1_waddr,
  output logic [LEN_WIDTH-1:0]    arg_1_wdata,
  output logic                    arg_1_wen,
  input  logic [LEN_WIDTH-1:0]    arg_1_rdata,
  output logic [ADDR_WIDTH-1:0]   arg_2_raddr,
  output logic [ADDR_WIDTH-1:0]   arg_2_waddr,
  output logic [ADDR_WIDTH-1:0]   arg_2_wdata,
  output logic                    arg_2_wen,
  input  logic [ADDR_WIDTH-1:0]   arg_2_rdata,
  output logic [DATA_WIDTH-1:0]   arg_0_in_data,
  output logic                    arg_0_write_valid,
  input  logic                    arg_0_write_ready,
  output logic                    arg_0_read_valid,
  input  logic [DATA_WIDTH-1:0]   arg_0_out_data,
  input  logic                    arg_0_read_ready,
  output logic                    valid
);

  localparam int unsigned CNT_W = LEN_WIDTH + 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_arvalid;
  logic                  r_valid;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [LEN_WIDTH-1:0]  r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  w_cnt_done;
  logic                  w_rready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_unused;

  assign w_cnt_done = (r_cnt == {1'b0, r_len});
  // Ready depends only on registered state so the FIFO's ready never reaches the R channel.
  assign w_rready   = (r_state == S_DATA) && !w_full && !w_cnt_done;
  assign w_push     = arg_3_s_axi_rvalid && w_rready;
  assign w_pop      = !w_empty && arg_0_write_ready;

  axi_rb_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_push    (w_push),
    .i_data    (arg_3_s_axi_rdata),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_LOAD;
      r_arvalid <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arvalid <= (w_state_nxt == S_AR);
      r_valid   <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  w_state_nxt = (arg_1_rdata == '0) ? S_DONE : S_AR;
      S_AR:    if (r_arvalid && arg_3_s_axi_arready) w_state_nxt = S_DATA;
      S_DATA:  if (w_cnt_done && w_empty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Burst descriptor captured once in LOAD; held stable through the AR phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        r_len     <= arg_1_rdata;
        r_araddr  <= arg_2_rdata;
        r_arlen   <= LEN_WIDTH'(arg_1_rdata - LEN_WIDTH'(1));
        r_arsize  <= AXI_SIZE_4B;
        r_arburst <= AXI_BURST_INCR;
        r_cnt     <= '0;
      end else if (w_push) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign arg_3_s_axi_araddr  = r_araddr;
  assign arg_3_s_axi_arlen   = r_arlen;
  assign arg_3_s_axi_arsize  = r_arsize;
  assign arg_3_s_axi_arburst = r_arburst;
  assign arg_3_s_axi_arvalid = r_arvalid;
  assign arg_3_s_axi_rready  = w_rready;
  assign arg_0_in_data       = w_head;
  assign arg_0_write_valid   = !w_empty;
  assign valid               = r_valid;

  assign arg_3_s_axi_awaddr  = '0;
  assign arg_3_s_axi_awburst = '0;
  assign arg_3_s_axi_awlen   = '0;
  assign arg_3_s_axi_awsize  = '0;
  assign arg_3_s_axi_awvalid = 1'b0;
  assign arg_3_s_axi_wdata   = '0;
  assign arg_3_s_axi_wstrb   = '0;
  assign arg_3_s_axi_wvalid  = 1'b0;
  assign arg_3_s_axi_bready  = 1'b0;
  assign arg_1_raddr         = '0;
  assign arg_1_waddr         = '0;
  assign arg_1_wdata         = '0;
  assign arg_1_wen           = 1'b0;
  assign arg_2_raddr         = '0;
  assign arg_2_waddr         = '0;
  assign arg_2_wdata         = '0;
  assign arg_2_wen           = 1'b0;
  assign arg_0_read_valid    = 1'b0;

  assign w_unused = ^{arg_3_s_axi_awready, arg_3_s_axi_wready, arg_3_s_axi_bvalid,
                      arg_0_out_data, arg_0_read_ready};

endmodule

// File: tb/tb_axi_rb.sv
// Directed bench for axi_rb: cycle-level reference of the AR/R/FIFO handshakes.
module tb_axi_rb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] araddr;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [15:0] awaddr;
  logic [1:0]  awburst;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready, bvalid, bready;
  logic [7:0]  a1_raddr, a1_waddr, a1_wdata, a1_rdata;
  logic        a1_wen;
  logic [15:0] a2_raddr, a2_waddr, a2_wdata, a2_rdata;
  logic        a2_wen;
  logic [31:0] in_data, out_data;
  logic        write_valid, write_ready, read_valid, read_ready;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_rb dut (
    .clk(clk), .rst(rst),
    .arg_3_s_axi_araddr(araddr), .arg_3_s_axi_arburst(arburst), .arg_3_s_axi_arlen(arlen),
    .arg_3_s_axi_arsize(arsize), .arg_3_s_axi_arvalid(arvalid), .arg_3_s_axi_arready(arready),
    .arg_3_s_axi_rdata(rdata), .arg_3_s_axi_rvalid(rvalid), .arg_3_s_axi_rready(rready),
    .arg_3_s_axi_awaddr(awaddr), .arg_3_s_axi_awburst(awburst), .arg_3_s_axi_awlen(awlen),
    .arg_3_s_axi_awsize(awsize), .arg_3_s_axi_awvalid(awvalid), .arg_3_s_axi_awready(awready),
    .arg_3_s_axi_wdata(wdata), .arg_3_s_axi_wstrb(wstrb), .arg_3_s_axi_wvalid(wvalid),
    .arg_3_s_axi_wready(wready), .arg_3_s_axi_bvalid(bvalid), .arg_3_s_axi_bready(bready),
    .arg_1_raddr(a1_raddr), .arg_1_waddr(a1_waddr), .arg_1_wdata(a1_wdata), .arg_1_wen(a1_wen),
    .arg_1_rdata(a1_rdata),
    .arg_2_raddr(a2_raddr), .arg_2_waddr(a2_waddr), .arg_2_wdata(a2_wdata), .arg_2_wen(a2_wen),
    .arg_2_rdata(a2_rdata),
    .arg_0_in_data(in_data), .arg_0_write_valid(write_valid), .arg_0_write_ready(write_ready),
    .arg_0_read_valid(read_valid), .arg_0_out_data(out_data), .arg_0_read_ready(read_ready),
    .valid(valid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [15:0] a, input int k);
    return {a, 16'(k)} ^ 32'h5A5A_0000;
  endfunction

  // wr_mode: 0 ready always, 1 stall cycles 4..13, 2 toggle, 3 never ready.
  task automatic burst(input int n, input logic [15:0] a, input int ar_delay,
                       input int wr_mode, input int abort_at);
    int  cyc = 0, acc = 0, popped = 0, occ = 0, post = 0;
    int  dut_ar = 0, dut_push = 0, last_beat = -1, valid_cyc = -1;
    bit  ar_done = 0, data_ph = 0, done_exp = 0, go_done;
    bit  arv_e, rr_e, wv_e, ar_hs, r_hs, w_hs;

    @(negedge clk);
    rst = 1'b1; a1_rdata = 8'(n); a2_rdata = a;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; write_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_outs", 64'(|{araddr, arburst, arlen, arsize, arvalid, rready, in_data,
                         write_valid, valid}), 64'd0);
    chk("tieoffs", 64'(|{awaddr, awburst, awlen, awsize, awvalid, wdata, wstrb, wvalid, bready,
                        a1_raddr, a1_waddr, a1_wdata, a1_wen, a2_raddr, a2_waddr, a2_wdata,
                        a2_wen, read_valid}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      arready = (n != 0) && (cyc >= 1 + ar_delay);
      rvalid  = (acc < n);
      rdata   = word_of(a, acc);
      case (wr_mode)
        1:       write_ready = !(cyc >= 4 && cyc < 14);
        2:       write_ready = (cyc % 2) == 1;
        3:       write_ready = 1'b0;
        default: write_ready = 1'b1;
      endcase
      #1;
      arv_e = (cyc >= 1) && (n != 0) && !ar_done;
      rr_e  = data_ph && (occ < 2) && (acc < n);
      wv_e  = (occ != 0);
      chk("arvalid", 64'(arvalid), 64'(arv_e));
      chk("rready", 64'(rready), 64'(rr_e));
      chk("wvalid", 64'(write_valid), 64'(wv_e));
      chk("valid", 64'(valid), 64'(done_exp));
      if (arvalid) begin
        chk("araddr", 64'(araddr), 64'(a));
        chk("arlen", 64'(arlen), 64'(n - 1));
        chk("arsize", 64'(arsize), 64'd2);
        chk("arburst", 64'(arburst), 64'd1);
      end
      ar_hs = arv_e && arready;
      r_hs  = rvalid && rr_e;
      w_hs  = wv_e && write_ready;
      if (w_hs) chk("word", 64'(in_data), 64'(word_of(a, popped)));
      if (arvalid && arready) dut_ar++;
      if (write_valid && write_ready) dut_push++;
      if (rvalid && rready) last_beat = cyc;
      if (valid && valid_cyc < 0) valid_cyc = cyc;

      go_done = (cyc == 0 && n == 0) || (data_ph && acc == n && occ == 0);
      if (ar_hs) begin ar_done = 1; data_ph = 1; end
      if (r_hs) acc++;
      if (w_hs) popped++;
      occ = occ + int'(r_hs) - int'(w_hs);
      if (go_done) begin done_exp = 1; data_ph = 0; end
      if (done_exp) post++;
      cyc++;
      if (abort_at > 0 && acc >= abort_at) break;
      if (post > 3) break;
      @(negedge clk);
    end

    if (abort_at == 0) begin
      chk("timeout", 64'(valid_cyc >= 0), 64'd1);
      chk("nwords", 64'(dut_push), 64'(n));
      chk("ar_count", 64'(dut_ar), 64'(n != 0));
      if (wr_mode == 0 && n != 0)
        chk("done_lat", 64'((valid_cyc - last_beat) <= 3), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    a1_rdata = '0; a2_rdata = '0; write_ready = 1'b1; out_data = '0; read_ready = 1'b0;

    burst(4, 16'h0100, 0, 0, 0);
    burst(4, 16'h0200, 5, 0, 0);
    burst(6, 16'h0300, 0, 1, 0);
    burst(7, 16'h0400, 0, 2, 0);
    burst(0, 16'h0500, 0, 0, 0);
    burst(8, 16'h0600, 0, 3, 2);
    burst(3, 16'h0700, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
